block_ram_access_controller: RTL and testbench
==============================================

# block_ram_access_controller

Request/response front end placed directly upstream of the 1-RW, 1-cycle-latency block RAM. It converts a valid/ready request stream (reads and writes) into RAM index/write strobes, captures read data from the RAM's registered output into a 2-entry response queue with back-pressure, and runs a zero-fill clear sequence after reset and on demand. Consumers see a clean valid/ready read-response stream and never need to track RAM latency.

## Interface
Parameters:
- DATA_WIDTH, 32, RAM word width
- INDEX_WIDTH, 8, RAM address width; EntryCount = 1 << INDEX_WIDTH

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- clearStart  in  1  pulse; request a full zero-fill while in RUN
- clearDone  out  1  1 when in RUN (RAM contents valid)
- reqValid  in  1  request present
- reqReady  out  1  request accepted when reqValid && reqReady
- reqWrite  in  1  1 = write, 0 = read
- reqIndex  in  INDEX_WIDTH  address
- reqWriteValue  in  DATA_WIDTH  write data
- respValid  out  1  read data available
- respReady  in  1  consumer takes data when respValid && respReady
- respReadValue  out  DATA_WIDTH  read data, oldest first
- ramIndex  out  INDEX_WIDTH  to RAM index
- ramWriteValue  out  DATA_WIDTH  to RAM writeValue
- ramWriteEnable  out  1  to RAM writeEnable
- ramReadValue  in  DATA_WIDTH  from RAM readValue (registered, 1 cycle)

## Operation
- States: CLEAR, RUN, DRAIN. Reset state CLEAR, clearIndex = 0.
- CLEAR: ramIndex = clearIndex, ramWriteValue = 0, ramWriteEnable = 1; clearIndex += 1 per cycle; after index EntryCount-1 written -> RUN. reqReady = 0.
- RUN: reqReady = (inflight + count < 2) || (respValid && respReady). On accept: ramIndex = reqIndex; write drives ramWriteEnable = 1, ramWriteValue = reqWriteValue, no response; read sets inflight = 1 for the next cycle. When not accepting, ramWriteEnable = 0, ramIndex = reqIndex (don't care).
- inflight: 1-bit; in the cycle after a read accept, ramReadValue is pushed into the queue.
- Response queue: 2 entries, FIFO; push and pop in the same cycle allowed at any occupancy (including full pop + push). Never overflows given reqReady rule; overflow is an assertion error.
- clearStart in RUN -> DRAIN: reqReady = 0; wait until inflight = 0, then CLEAR with clearIndex = 0. Queued responses remain deliverable during DRAIN/CLEAR. clearStart ignored outside RUN.
- Write then read of same index on consecutive accepts returns the new value.

## Timing
- Reset values: reqReady 0, respValid 0, clearDone 0, ramWriteEnable 0 (forced 0 while rst high), ramIndex 0, respReadValue 0, queue empty, inflight 0.
- rst asserted mid-operation: queue and inflight discarded immediately; after release, clear restarts at index 0.
- Clear takes exactly EntryCount cycles; clearDone rises the cycle after last clear write.
- Read latency: accept in cycle t -> ramReadValue valid in t+1 -> respValid in t+2.
- Throughput: one request per cycle sustained while respReady = 1.
- respValid/respReadValue stable until popped.
- reqReady combinationally depends on respReady (pop credit); no other comb. paths input->output except ramIndex/ramWrite* from req*.

## Structure
- Package BlockRamAccessTypes: state enum (CLEAR, RUN, DRAIN), QUEUE_DEPTH = 2 constant.
- Sub-module resp_queue2: parameterised DATA_WIDTH 2-entry FIFO with push/pop/count, reset async.
- Top holds FSM, clearIndex counter, inflight bit, RAM muxing.

## Test plan
- Reset release, INDEX_WIDTH=4 -> ramWriteEnable=1 for 16 cycles with indices 0..15, value 0; clearDone=1 on cycle 17; then reads of 0..15 all return 0.
- Write 0xDEADBEEF at 5, read 5 next cycle -> respValid 2 cycles after read accept with 0xDEADBEEF.
- Back-to-back reads of 1,2,3,4 with respReady=1 -> reqReady held 1, responses in order, one per cycle.
- respReady=0 with reads streaming -> exactly 2 reads accepted, reqReady=0; raise respReady -> reqReady=1 same cycle, order preserved.
- clearStart with one read inflight -> DRAIN until response queued, then 2^INDEX_WIDTH clear cycles; queued response still delivered; prior writes read back as 0.
- rst pulse with 2 queued responses -> respValid=0 immediately, clear restarts at index 0.

Source files
------------

// File: rtl/block_ram_access_controller_pkg.sv
// Shared types for the block RAM access controller: controller states and
// response queue depth.
package BlockRamAccessTypes;

    typedef enum logic [1:0] {
        CLEAR,
        RUN,
        DRAIN
    } state_t;

    localparam int QUEUE_DEPTH = 2;

endpackage

// File: rtl/block_ram_access_controller_resp_queue2.sv
// Two-entry FIFO holding read responses captured from the RAM output.
// A push and a pop may happen in the same cycle at any occupancy.
module resp_queue2
    import BlockRamAccessTypes::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_value,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] pop_value,
    output logic [1:0]            count,
    output logic                  not_empty
);

    localparam logic [1:0] FULL_COUNT = 2'(QUEUE_DEPTH);

    logic [DATA_WIDTH-1:0] entries [QUEUE_DEPTH];
    logic                  rd_ptr;
    logic                  wr_ptr;

    // When full, wr_ptr equals rd_ptr, so a simultaneous pop+push overwrites
    // exactly the slot being handed out this cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entries[0] <= '0;
            entries[1] <= '0;
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            count      <= 2'd0;
        end else begin
            if (push) begin
                entries[wr_ptr] <= push_value;
                wr_ptr          <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign pop_value = entries[rd_ptr];
    assign not_empty = (count != 2'd0);

    overflow_check: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && count == FULL_COUNT));

    underflow_check: assert property (@(posedge clk) disable iff (rst)
        !(pop && count == 2'd0));

endmodule

// File: rtl/block_ram_access_controller.sv
// Valid/ready front end for a 1-cycle-latency single-port block RAM: request
// muxing, read-response capture with back-pressure, and zero-fill clearing.
module block_ram_access_controller
    import BlockRamAccessTypes::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int INDEX_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clearStart,
    output logic                   clearDone,
    input  logic                   reqValid,
    output logic                   reqReady,
    input  logic                   reqWrite,
    input  logic [INDEX_WIDTH-1:0] reqIndex,
    input  logic [DATA_WIDTH-1:0]  reqWriteValue,
    output logic                   respValid,
    input  logic                   respReady,
    output logic [DATA_WIDTH-1:0]  respReadValue,
    output logic [INDEX_WIDTH-1:0] ramIndex,
    output logic [DATA_WIDTH-1:0]  ramWriteValue,
    output logic                   ramWriteEnable,
    input  logic [DATA_WIDTH-1:0]  ramReadValue
);

    state_t                 state;
    state_t                 state_next;
    logic [INDEX_WIDTH-1:0] clear_index;
    logic                   inflight;
    logic                   accept;
    logic                   pop;
    logic [1:0]             queue_count;

    // clear_index is held at zero outside CLEAR so every clear starts at 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= CLEAR;
            clear_index <= '0;
            inflight    <= 1'b0;
        end else begin
            state    <= state_next;
            inflight <= accept && !reqWrite;
            if (state == CLEAR) begin
                clear_index <= clear_index + INDEX_WIDTH'(1);
            end else begin
                clear_index <= '0;
            end
        end
    end

    always_comb begin
        state_next     = state;
        reqReady       = 1'b0;
        accept         = 1'b0;
        ramIndex       = reqIndex;
        ramWriteValue  = reqWriteValue;
        ramWriteEnable = 1'b0;
        case (state)
            CLEAR: begin
                ramIndex       = clear_index;
                ramWriteValue  = '0;
                ramWriteEnable = 1'b1;
                if (&clear_index) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                // A pop this cycle frees a slot, so it counts as credit.
                reqReady       = (({1'b0, inflight} + queue_count) < 2'd2) || pop;
                accept         = reqValid && reqReady;
                ramWriteEnable = accept && reqWrite;
                if (clearStart) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (!inflight) begin
                    state_next = CLEAR;
                end
            end
            default: begin
                state_next = CLEAR;
            end
        endcase
        if (rst) begin
            ramWriteEnable = 1'b0;
        end
    end

    assign pop       = respValid && respReady;
    assign clearDone = (state == RUN);

    resp_queue2 #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_resp_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight),
        .push_value(ramReadValue),
        .pop       (pop),
        .pop_value (respReadValue),
        .count     (queue_count),
        .not_empty (respValid)
    );

endmodule

// File: tb/tb_block_ram_access_controller.sv
// Scoreboard bench for block_ram_access_controller with a behavioural
// 1-cycle-latency RAM; expected read data comes from a shadow memory.
module tb_block_ram_access_controller;

    localparam int DW = 32;
    localparam int IW = 4;
    localparam int N  = 1 << IW;

    logic          clk = 1'b0;
    logic          rst;
    logic          clearStart;
    logic          clearDone;
    logic          reqValid;
    logic          reqReady;
    logic          reqWrite;
    logic [IW-1:0] reqIndex;
    logic [DW-1:0] reqWriteValue;
    logic          respValid;
    logic          respReady;
    logic [DW-1:0] respReadValue;
    logic [IW-1:0] ramIndex;
    logic [DW-1:0] ramWriteValue;
    logic          ramWriteEnable;
    logic [DW-1:0] ramReadValue;

    logic [DW-1:0] ram    [N];
    logic [DW-1:0] shadow [N];
    logic [DW-1:0] expq   [$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    block_ram_access_controller #(
        .DATA_WIDTH (DW),
        .INDEX_WIDTH(IW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .clearStart    (clearStart),
        .clearDone     (clearDone),
        .reqValid      (reqValid),
        .reqReady      (reqReady),
        .reqWrite      (reqWrite),
        .reqIndex      (reqIndex),
        .reqWriteValue (reqWriteValue),
        .respValid     (respValid),
        .respReady     (respReady),
        .respReadValue (respReadValue),
        .ramIndex      (ramIndex),
        .ramWriteValue (ramWriteValue),
        .ramWriteEnable(ramWriteEnable),
        .ramReadValue  (ramReadValue)
    );

    // Registered-output RAM model, read-before-write.
    always @(posedge clk) begin
        if (ramWriteEnable === 1'b1) begin
            ram[ramIndex] <= ramWriteValue;
        end
        ramReadValue <= ram[ramIndex];
    end

    task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                               input logic [DW-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
        end
    endtask

    // Monitor: every completed response handshake pops the scoreboard.
    always @(negedge clk) begin
        if (rst === 1'b0 && respValid === 1'b1 && respReady === 1'b1) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_resp: actual=%h required=none", respReadValue);
            end else begin
                checkOutput("resp_data", respReadValue, expq.pop_front());
            end
        end
    end

    task automatic applyStimulus(input logic wr, input int idx, input logic [DW-1:0] val);
        reqValid      = 1'b1;
        reqWrite      = wr;
        reqIndex      = IW'(idx);
        reqWriteValue = val;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (reqReady === 1'b1) begin
                if (wr) shadow[idx] = val;
                else    expq.push_back(shadow[idx]);
                @(posedge clk);
                #1;
                return;
            end
        end
        checks++;
        errors++;
        $display("[TB] FAIL req_timeout: actual=no_accept required=accept idx=%0d", idx);
    endtask

    task automatic streamReads(input int first, input int cycles,
                               output int accepted, output logic firstReady);
        accepted   = 0;
        firstReady = 1'b0;
        reqValid   = 1'b1;
        reqWrite   = 1'b0;
        reqIndex   = IW'(first);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (c == 0) firstReady = reqReady;
            if (reqReady === 1'b1) begin
                expq.push_back(shadow[(first + accepted) % N]);
                accepted++;
            end
            @(posedge clk);
            #1;
            reqIndex = IW'(first + accepted);
        end
    endtask

    task automatic idleCycles(input int n);
        reqValid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkClearSequence();
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            checkOutput("clear_we", ramWriteEnable, 1);
            checkOutput("clear_index", ramIndex, i);
            checkOutput("clear_value", ramWriteValue, 0);
            checkOutput("clear_done_low", clearDone, 0);
        end
        @(negedge clk);
        checkOutput("clear_done_high", clearDone, 1);
        checkOutput("run_we_idle", ramWriteEnable, 0);
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) shadow[i] = '0;
    endtask

    initial begin
        int   acc;
        logic rdy;

        for (int i = 0; i < N; i++) begin
            ram[i]    = 32'hA5A5_0000 + i;
            shadow[i] = '0;
        end
        ramReadValue  = '0;
        rst           = 1'b1;
        clearStart    = 1'b0;
        reqValid      = 1'b0;
        reqWrite      = 1'b0;
        reqIndex      = '0;
        reqWriteValue = '0;
        respReady     = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_reqReady", reqReady, 0);
        checkOutput("rst_respValid", respValid, 0);
        checkOutput("rst_clearDone", clearDone, 0);
        checkOutput("rst_ramWriteEnable", ramWriteEnable, 0);
        checkOutput("rst_ramIndex", ramIndex, 0);
        checkOutput("rst_respReadValue", respReadValue, 0);

        @(posedge clk);
        #1;
        rst = 1'b0;
        checkClearSequence();

        $display("[TB] read back cleared memory");
        streamReads(0, N, acc, rdy);
        checkOutput("clear_reads_accepted", acc, N);
        checkOutput("clear_reads_ready", rdy, 1);
        idleCycles(4);

        $display("[TB] write then read same index");
        applyStimulus(1'b1, 5, 32'hDEAD_BEEF);
        applyStimulus(1'b0, 5, '0);
        reqValid = 1'b0;
        @(negedge clk);
        checkOutput("latency_t1", respValid, 0);
        @(negedge clk);
        checkOutput("latency_t2", respValid, 1);
        idleCycles(3);

        $display("[TB] back-to-back reads");
        for (int i = 1; i <= 4; i++) applyStimulus(1'b1, i, 32'h1111_0000 + i);
        streamReads(1, 4, acc, rdy);
        checkOutput("b2b_accepted", acc, 4);
        checkOutput("b2b_ready", rdy, 1);
        idleCycles(4);

        $display("[TB] back-pressure");
        respReady = 1'b0;
        streamReads(1, 6, acc, rdy);
        checkOutput("bp_accepted", acc, 2);
        #1;
        checkOutput("bp_ready_low", reqReady, 0);
        respReady = 1'b1;
        #1;
        checkOutput("bp_ready_credit", reqReady, 1);
        streamReads(3, 2, acc, rdy);
        checkOutput("bp_resume_accepted", acc, 2);
        idleCycles(4);

        $display("[TB] clear with read in flight");
        applyStimulus(1'b1, 7, 32'hCAFE_0007);
        respReady  = 1'b0;
        clearStart = 1'b1;
        applyStimulus(1'b0, 7, '0);
        clearStart = 1'b0;
        reqValid   = 1'b0;
        @(negedge clk);
        checkOutput("drain_reqReady", reqReady, 0);
        checkOutput("drain_clearDone", clearDone, 0);
        @(negedge clk);
        checkOutput("drain_clearDone2", clearDone, 0);
        checkOutput("drain_respValid", respValid, 1);
        checkOutput("drain_we", ramWriteEnable, 0);
        checkClearSequence();
        checkOutput("after_clear_respValid", respValid, 1);
        respReady = 1'b1;
        idleCycles(2);
        applyStimulus(1'b0, 7, '0);
        idleCycles(4);

        $display("[TB] reset with queued responses");
        respReady = 1'b0;
        streamReads(2, 4, acc, rdy);
        checkOutput("rst_fill_accepted", acc, 2);
        idleCycles(2);
        checkOutput("rst_fill_respValid", respValid, 1);
        rst = 1'b1;
        #1;
        checkOutput("rst_mid_respValid", respValid, 0);
        checkOutput("rst_mid_we", ramWriteEnable, 0);
        expq.delete();
        repeat (2) @(posedge clk);
        #1;
        rst       = 1'b0;
        respReady = 1'b1;
        checkClearSequence();
        applyStimulus(1'b0, 2, '0);
        idleCycles(4);

        checkOutput("scoreboard_empty", expq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
